// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, ALU/writeback encodings and FSM states for the RV32I multi-cycle controller
package ctrl_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_OR,
    ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
  } alu_op_e;
  typedef enum logic [1:0] {WB_PC4 = 2'b00, WB_ALU = 2'b01, WB_LOAD = 2'b10} wb_sel_e;
  typedef enum logic [2:0] {S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP} cls_e;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational decode of the latched instruction into class and datapath selects
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output cls_e        cls,
  output alu_op_e     alu_op,
  output logic        opa_sel,
  output logic        opb_sel,
  output wb_sel_e     wb_sel,
  output logic        legal
);
  logic [6:0] op;
  logic [2:0] f3;
  logic       alt;
  logic       unused_ir;
  alu_op_e    f3_op;
  assign op = ir[6:0];
  assign f3 = ir[14:12];
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};
  // instr[30] picks SUB only for register ops, SRA/SRAI for both
  assign alt = ir[30] && (f3 == 3'd5 || (f3 == 3'd0 && op == OP_REG));
  always_comb begin
    case (f3)
      3'd0:    f3_op = ALU_ADD;
      3'd1:    f3_op = ALU_SLL;
      3'd2:    f3_op = ALU_SLT;
      3'd3:    f3_op = ALU_SLTU;
      3'd4:    f3_op = ALU_XOR;
      3'd5:    f3_op = ALU_SRL;
      3'd6:    f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  end
  always_comb begin
    cls = C_ALU;
    alu_op = ALU_ADD;
    opa_sel = 1'b0;
    opb_sel = 1'b1;
    wb_sel = WB_ALU;
    legal = 1'b1;
    case (op)
      OP_REG: begin
        opb_sel = 1'b0;
        alu_op = alt ? (f3[2] ? ALU_SRA : ALU_SUB) : f3_op;
      end
      OP_IMM:    alu_op = alt ? ALU_SRA : f3_op;
      OP_LUI:    alu_op = ALU_PASSB;
      OP_AUIPC:  opa_sel = 1'b1;
      OP_LOAD: begin
        cls = C_LOAD;
        wb_sel = WB_LOAD;
      end
      OP_STORE:  cls = C_STORE;
      OP_BRANCH: begin
        cls = C_BRANCH;
        opa_sel = 1'b1;
      end
      OP_JAL: begin
        cls = C_JUMP;
        opa_sel = 1'b1;
        wb_sel = WB_PC4;
      end
      OP_JALR: begin
        cls = C_JUMP;
        wb_sel = WB_PC4;
      end
      default:   legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle RV32I control FSM with fetch/memory handshakes and timeout fault
// Optional CTRL_PERF_EN adds retired_cnt/stall_cnt performance counters.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int TO_W     = 8,
  parameter int TO_CYC   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                instr_vld,
  input  logic                mem_ack,
  input  logic                br_less,
  input  logic                br_equal,
  output logic                fetch_req,
  output logic                ir_wren,
  output logic                pc_wren,
  output logic                pc_sel,
  output logic                rd_wren,
  output logic                insn_vld,
  output logic                br_un,
  output logic                opa_sel,
  output logic                opb_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_req,
  output logic                mem_wren,
  output logic [1:0]          wb_sel,
  output logic                fault
`ifdef CTRL_PERF_EN
  ,
  output logic [31:0]         retired_cnt,
  output logic [31:0]         stall_cnt
`endif
);
  state_e          state, nxt;
  logic [31:0]     ir;
  logic [TO_W-1:0] to_cnt;
  cls_e            cls;
  alu_op_e         dec_op;
  wb_sel_e         dec_wb;
  logic            dec_opa, dec_opb, legal;
  logic            waiting, hs, to_hit, taken, is_br, is_st;
  ctrl_decode u_dec (
    .ir      (ir),
    .cls     (cls),
    .alu_op  (dec_op),
    .opa_sel (dec_opa),
    .opb_sel (dec_opb),
    .wb_sel  (dec_wb),
    .legal   (legal)
  );
  assign waiting = state == S_FETCH || state == S_MEM;
  assign hs = state == S_FETCH ? instr_vld : mem_ack;
  assign to_hit = to_cnt == TO_W'(TO_CYC - 1);
  assign is_br = cls == C_BRANCH;
  assign is_st = cls == C_STORE;
  // funct3[2] picks less/equal compare, funct3[0] inverts it
  assign taken = ir[14] ? (br_less ^ ir[12]) : (br_equal ^ ir[12]);
  assign fault = state == S_HALT;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET;
      ir <= '0;
      to_cnt <= '0;
    end else begin
      state <= nxt;
      ir <= ir_wren ? instr : ir;
      to_cnt <= (waiting && !hs) ? to_cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    nxt = state;
    fetch_req = 1'b0;
    ir_wren = 1'b0;
    pc_wren = 1'b0;
    pc_sel = 1'b0;
    rd_wren = 1'b0;
    insn_vld = 1'b0;
    br_un = 1'b0;
    opa_sel = 1'b0;
    opb_sel = 1'b0;
    alu_op = '0;
    mem_req = 1'b0;
    mem_wren = 1'b0;
    wb_sel = 2'b00;
    case (state)
      S_RESET: nxt = S_FETCH;
      S_FETCH: begin
        fetch_req = 1'b1;
        ir_wren = instr_vld;
        nxt = instr_vld ? S_DECODE : to_hit ? S_HALT : S_FETCH;
      end
      S_DECODE: begin
        pc_wren = !legal;
        nxt = legal ? S_EXEC : S_FETCH;
      end
      S_EXEC: begin
        opa_sel = dec_opa;
        opb_sel = dec_opb;
        alu_op = ALU_OP_W'(dec_op);
        br_un = is_br && ir[13];
        pc_wren = is_br;
        pc_sel = is_br && taken;
        insn_vld = is_br;
        nxt = is_br ? S_FETCH : (cls == C_LOAD || is_st) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_wren = is_st;
        pc_wren = mem_ack && is_st;
        insn_vld = mem_ack && is_st;
        nxt = mem_ack ? (is_st ? S_FETCH : S_WB) : to_hit ? S_HALT : S_MEM;
      end
      S_WB: begin
        rd_wren = |ir[11:7];
        insn_vld = 1'b1;
        pc_wren = 1'b1;
        pc_sel = cls == C_JUMP;
        wb_sel = dec_wb;
        nxt = S_FETCH;
      end
      default: nxt = state;
    endcase
  end
`ifdef CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      retired_cnt <= retired_cnt + 32'(insn_vld);
      stall_cnt <= stall_cnt + 32'(waiting && !hs);
    end
  end
`endif
endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: vector table, corner sequences and random instructions against a transaction-level model
module tb_ctrl_fsm;
  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_vld = 1'b0, mem_ack = 1'b0, br_less = 1'b0, br_equal = 1'b0;
  logic        fetch_req, ir_wren, pc_wren, pc_sel, rd_wren, insn_vld, br_un;
  logic        opa_sel, opb_sel, mem_req, mem_wren, fault;
  logic [3:0]  alu_op;
  logic [1:0]  wb_sel;
  logic [17:0] all_out;
  logic [6:0]  strobes;
  int          checks = 0, errors = 0, exp_retired = 0;
`ifdef CTRL_PERF_EN
  logic [31:0] retired_cnt, stall_cnt;
`endif

  ctrl_fsm #(.ALU_OP_W(4), .TO_W(8), .TO_CYC(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_vld(instr_vld), .mem_ack(mem_ack),
    .br_less(br_less), .br_equal(br_equal), .fetch_req(fetch_req), .ir_wren(ir_wren),
    .pc_wren(pc_wren), .pc_sel(pc_sel), .rd_wren(rd_wren), .insn_vld(insn_vld),
    .br_un(br_un), .opa_sel(opa_sel), .opb_sel(opb_sel), .alu_op(alu_op),
    .mem_req(mem_req), .mem_wren(mem_wren), .wb_sel(wb_sel), .fault(fault)
`ifdef CTRL_PERF_EN
    , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;
  assign all_out = {fetch_req, ir_wren, pc_wren, pc_sel, rd_wren, insn_vld, br_un, opa_sel,
                    opb_sel, alu_op, mem_req, mem_wren, wb_sel, fault};
  assign strobes = {fetch_req, ir_wren, pc_wren, rd_wren, insn_vld, mem_req, mem_wren};

  typedef struct {
    logic [31:0] instr;
    int d, a;
    bit bl, be;
  } stim_t;
  // ret: cycle index (from first FETCH cycle) of the pc_wren pulse; exec fields are at cycle d+2
  typedef struct {
    int ret, alu, opa, opb, bun, psel, vld, rdw, wb, memc, memw;
  } exp_t;
  typedef struct {
    string nm;
    stim_t s;
    exp_t  e;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input stim_t s);
    exp_t e = '{default: 0};
    logic [6:0] op = s.instr[6:0];
    logic [2:0] f3 = s.instr[14:12];
    bit alt = s.instr[30];
    int rdnz = (s.instr[11:7] != 5'd0) ? 1 : 0;
    int base[8] = '{0, 7, 2, 3, 4, 8, 5, 6};
    bit tk;
    e.vld = 1;
    case (op)
      7'h33, 7'h13: begin
        e.alu = (alt && f3 == 3'd5) ? 9 : (alt && f3 == 3'd0 && op == 7'h33) ? 1 : base[f3];
        e.opb = (op == 7'h13) ? 1 : 0;
        e.wb = 1; e.rdw = rdnz; e.ret = s.d + 3;
      end
      7'h37: begin e.alu = 10; e.opb = 1; e.wb = 1; e.rdw = rdnz; e.ret = s.d + 3; end
      7'h17: begin e.opa = 1; e.opb = 1; e.wb = 1; e.rdw = rdnz; e.ret = s.d + 3; end
      7'h6F: begin e.opa = 1; e.opb = 1; e.psel = 1; e.rdw = rdnz; e.ret = s.d + 3; end
      7'h67: begin e.opb = 1; e.psel = 1; e.rdw = rdnz; e.ret = s.d + 3; end
      7'h63: begin
        case (f3)
          3'd0:       tk = s.be;
          3'd1:       tk = !s.be;
          3'd4, 3'd6: tk = s.bl;
          default:    tk = !s.bl;
        endcase
        e.opa = 1; e.opb = 1; e.bun = f3[1]; e.psel = tk; e.ret = s.d + 2;
      end
      7'h03: begin e.opb = 1; e.memc = s.a + 1; e.wb = 2; e.rdw = rdnz; e.ret = s.d + 4 + s.a; end
      7'h23: begin e.opb = 1; e.memc = s.a + 1; e.memw = 1; e.ret = s.d + 3 + s.a; end
      default: begin e.vld = 0; e.ret = s.d + 1; end
    endcase
    return e;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; instr_vld = 1'b0; mem_ack = 1'b0;
    #1 chk("reset.outs", int'(all_out), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("reset.release", int'(all_out), 0);
    exp_retired = 0;
  endtask

  task automatic run(input string nm, input stim_t s, input exp_t e);
    int ret = -1, nf = 0, nirw = 0, irt = -1, nmr = 0, nrd = 0, nvld = 0, flt = 0, memw = 0;
    int psel = 0, vld = 0, wb = 0, alu = 0, opa = 0, opb = 0, bun = 0;
    int ms = s.d + 3;
    for (int t = 0; t < 64 && ret < 0; t++) begin
      @(negedge clk);
      instr = (t == s.d) ? s.instr : $urandom;
      instr_vld = (t < s.d) ? 1'b0 : (t == s.d) ? 1'b1 : 1'($urandom);
      mem_ack = (e.memc > 0 && t >= ms && t <= ms + s.a) ? (t == ms + s.a) : 1'($urandom);
      br_less = s.bl; br_equal = s.be;
      #1;
      if (fetch_req) nf++;
      if (ir_wren) begin nirw++; irt = t; end
      if (mem_req) nmr++;
      if (mem_wren) memw = 1;
      if (rd_wren) nrd++;
      if (insn_vld) nvld++;
      if (fault) flt = 1;
      if (t == s.d + 2) begin alu = alu_op; opa = opa_sel; opb = opb_sel; bun = br_un; end
      if (pc_wren) begin ret = t; psel = pc_sel; vld = insn_vld; wb = wb_sel; end
    end
    chk({nm, ".retire_cycle"}, ret, e.ret);
    chk({nm, ".fetch_cycles"}, nf, s.d + 1);
    chk({nm, ".ir_wren_count"}, nirw, 1);
    chk({nm, ".ir_wren_cycle"}, irt, s.d);
    chk({nm, ".insn_vld"}, vld, e.vld);
    chk({nm, ".insn_vld_count"}, nvld, e.vld);
    chk({nm, ".pc_sel"}, psel, e.psel);
    chk({nm, ".wb_sel"}, wb, e.wb);
    chk({nm, ".rd_wren_count"}, nrd, e.rdw);
    chk({nm, ".mem_req_cycles"}, nmr, e.memc);
    chk({nm, ".mem_wren"}, memw, e.memw);
    chk({nm, ".fault"}, flt, 0);
    if (e.ret >= s.d + 2) begin
      chk({nm, ".alu_op"}, alu, e.alu);
      chk({nm, ".opa_sel"}, opa, e.opa);
      chk({nm, ".opb_sel"}, opb, e.opb);
      chk({nm, ".br_un"}, bun, e.bun);
    end
    exp_retired += e.vld;
    if (ret < 0) do_reset();
  endtask

  vec_t tbl[14];
  stim_t rs;
  int ops[9] = '{'h33, 'h13, 'h37, 'h17, 'h6F, 'h67, 'h63, 'h03, 'h23};
  int bad[4] = '{'h7F, 'h00, 'h0F, 'h73};
  int bf3[6] = '{0, 1, 4, 5, 6, 7};

  initial begin
    tbl = '{
      '{"add",    '{32'h002081B3, 0, 0, 0, 0}, '{3, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0}},
      '{"sub",    '{32'h402081B3, 2, 0, 0, 0}, '{5, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0}},
      '{"srai",   '{32'h40335293, 0, 0, 0, 0}, '{3, 9, 0, 1, 0, 0, 1, 1, 1, 0, 0}},
      '{"lui",    '{32'h123453B7, 0, 0, 0, 0}, '{3, 10, 0, 1, 0, 0, 1, 1, 1, 0, 0}},
      '{"bltu_t", '{32'h0020E463, 0, 0, 1, 0}, '{2, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0}},
      '{"bltu_n", '{32'h0020E463, 0, 0, 0, 1}, '{2, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0}},
      '{"lw",     '{32'h0000A203, 0, 3, 0, 0}, '{7, 0, 0, 1, 0, 0, 1, 1, 2, 4, 0}},
      '{"sw",     '{32'h0020A223, 0, 1, 0, 0}, '{4, 0, 0, 1, 0, 0, 1, 0, 0, 2, 1}},
      '{"illegal",'{32'h0000007F, 1, 0, 0, 0}, '{2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}},
      '{"jal",    '{32'h010000EF, 0, 0, 0, 0}, '{3, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0}},
      '{"jalr_x0",'{32'h00008067, 1, 0, 0, 0}, '{4, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0}},
      '{"auipc",  '{32'h00001117, 0, 0, 0, 0}, '{3, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0}},
      '{"beq_t",  '{32'h00208063, 0, 0, 0, 1}, '{2, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0}},
      '{"addi_x0",'{32'h00000013, 0, 0, 0, 0}, '{3, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0}}
    };
    repeat (2) @(posedge clk);
    do_reset();
    foreach (tbl[i]) run(tbl[i].nm, tbl[i].s, tbl[i].e);

    // load whose mem_ack never arrives: 16 wait cycles then sticky halt
    do_reset();
    begin
      int nmr = 0, strb = 0, f18 = -1;
      for (int t = 0; t < 26; t++) begin
        @(negedge clk);
        instr = (t == 0) ? 32'h0000A203 : $urandom;
        instr_vld = (t == 0) ? 1'b1 : (t >= 19) ? 1'($urandom) : 1'b0;
        mem_ack = (t >= 19) ? 1'($urandom) : 1'b0;
        #1;
        if (mem_req) nmr++;
        if (t == 18) f18 = fault;
        if (t >= 19) strb |= int'(strobes);
      end
      chk("to_mem.req_cycles", nmr, 16);
      chk("to_mem.fault_last_wait", f18, 0);
      chk("to_mem.fault", fault, 1);
      chk("to_mem.halt_strobes", strb, 0);
    end
    do_reset();
    run("after_halt.add", tbl[0].s, tbl[0].e);

    // fetch that never gets instr_vld
    begin
      int nf = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        instr_vld = 1'b0; mem_ack = 1'($urandom);
        #1 if (fetch_req) nf++;
      end
      chk("to_fetch.req_cycles", nf, 16);
      chk("to_fetch.fault", fault, 1);
    end

    // asynchronous reset in the middle of a memory wait
    do_reset();
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      instr = 32'h0020A223; instr_vld = (t == 0); mem_ack = 1'b0;
      #1;
    end
    chk("rst_mem.in_mem", {mem_req, mem_wren}, 2'b11);
    #1 rst = 1'b1;
    #1 chk("rst_mem.outs", int'(all_out), 0);
    @(negedge clk);
    chk("rst_mem.held", int'(all_out), 0);
    rst = 1'b0;
    exp_retired = 0;
    @(negedge clk);
    #1 chk("rst_mem.fetch", {fetch_req, mem_req, pc_wren}, 3'b100);
    run("after_rst.sw", tbl[7].s, tbl[7].e);

    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 9);
      rs.instr = $urandom;
      rs.instr[6:0] = (r < 9) ? 7'(ops[r]) : 7'(bad[$urandom_range(0, 3)]);
      if (rs.instr[6:0] == 7'h63) rs.instr[14:12] = 3'(bf3[$urandom_range(0, 5)]);
      rs.d = $urandom_range(0, 3);
      rs.a = $urandom_range(0, 4);
      rs.bl = 1'($urandom);
      rs.be = 1'($urandom);
      run($sformatf("rnd%0d", i), rs, model(rs));
    end
`ifdef CTRL_PERF_EN
    chk("perf.retired", int'(retired_cnt), exp_retired);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
